// File: rtl/fixed_pro_arb_pkg.sv
// fixed_pro_arb_pkg: shared arbiter defaults and a one-hot-or-zero helper.
package fixed_pro_arb_pkg;
    localparam int N_DEFAULT = 3;
    function automatic logic is_onehot0(input logic [31:0] v);
        return (v & (v - 32'd1)) == 32'd0;
    endfunction
endpackage

// File: rtl/fixed_pro_arb_prio_enc_lsb.sv
// prio_enc_lsb: isolates the lowest set bit of req (combinational).
module prio_enc_lsb #(
    parameter int N = 3
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);
    // Two's complement trick: carry out of N bits is dropped.
    always_comb gnt = req & (~req + N'(1));
endmodule

// File: rtl/fixed_pro_arb.sv
// fixed_pro_arb: fixed-priority arbiter, req[0] highest, registered one-hot grant.
module fixed_pro_arb
    import fixed_pro_arb_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] resp
);
    logic [N-1:0] resp_d, resp_q;
    prio_enc_lsb #(.N(N)) u_enc (.req(req), .gnt(resp_d));
    // rst_n is active-high despite its name.
    always_ff @(posedge clk or posedge rst_n)
        if (rst_n) resp_q <= '0;
        else resp_q <= resp_d;
    assign resp = resp_q;
    a_onehot0: assert property (@(posedge clk) disable iff (rst_n) is_onehot0(32'(resp_q)));
endmodule

// File: tb/tb_fixed_pro_arb.sv
// tb_fixed_pro_arb: scoreboard-driven bench for the fixed-priority arbiter.
module tb_fixed_pro_arb;
    localparam int N = 3;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] resp;
    logic [N-1:0] exp_q[$];
    logic [N-1:0] e;
    int n_checks = 0;
    int n_fail = 0;

    fixed_pro_arb #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .req(req), .resp(resp));

    always #5 clk = ~clk;

    function automatic logic [N-1:0] lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (v[i]) return N'(1) << i;
        return '0;
    endfunction

    // Called at a negedge: drive req, record expectation, advance to next negedge.
    task automatic step(input logic [N-1:0] v);
        req = v;
        exp_q.push_back(lowest(v));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        req = 3'b111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (resp !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_hold: resp=%b expected=000", resp);
            end
        end
        rst_n = 1'b0;
        step(3'b111);
        e = exp_q.pop_front();
        n_checks++;
        if (resp !== e) begin
            n_fail++;
            $display("FAIL reset_release: resp=%b expected=%b", resp, e);
        end
        step(3'b010);
        e = exp_q.pop_front();
        n_checks++;
        if (resp !== e) begin
            n_fail++;
            $display("FAIL pre_midreset: resp=%b expected=%b", resp, e);
        end
        #2 rst_n = 1'b1;
        #1;
        n_checks++;
        if (resp !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_async: resp=%b expected=000", resp);
        end
        @(negedge clk);
        n_checks++;
        if (resp !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid_hold: resp=%b expected=000", resp);
        end
        rst_n = 1'b0;
    endtask

    task automatic test_single();
        logic [N-1:0] pats[3] = '{3'b001, 3'b010, 3'b100};
        foreach (pats[i]) begin
            step(pats[i]);
            e = exp_q.pop_front();
            n_checks++;
            if (resp !== e) begin
                n_fail++;
                $display("FAIL single_%0d: req=%b resp=%b expected=%b", i, req, resp, e);
            end
        end
    endtask

    task automatic test_contention();
        logic [N-1:0] pats[4] = '{3'b111, 3'b110, 3'b101, 3'b011};
        logic [N-1:0] want[4] = '{3'b001, 3'b010, 3'b001, 3'b001};
        foreach (pats[i]) begin
            step(pats[i]);
            e = exp_q.pop_front();
            n_checks++;
            if (resp !== e || resp !== want[i]) begin
                n_fail++;
                $display("FAIL contention_%0d: req=%b resp=%b expected=%b", i, req, resp, want[i]);
            end
        end
    endtask

    task automatic test_preempt();
        logic [N-1:0] pats[4] = '{3'b100, 3'b100, 3'b110, 3'b100};
        foreach (pats[i]) begin
            step(pats[i]);
            e = exp_q.pop_front();
            n_checks++;
            if (resp !== e) begin
                n_fail++;
                $display("FAIL preempt_%0d: req=%b resp=%b expected=%b", i, req, resp, e);
            end
        end
    endtask

    task automatic test_idle();
        step(3'b000);
        e = exp_q.pop_front();
        n_checks++;
        if (resp !== 3'b000 || resp !== e) begin
            n_fail++;
            $display("FAIL idle: resp=%b expected=000", resp);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            step(N'($urandom_range(0, 7)));
            e = exp_q.pop_front();
            n_checks++;
            if (resp !== e) begin
                n_fail++;
                $display("FAIL random_%0d: req=%b resp=%b expected=%b", i, req, resp, e);
            end
            n_checks++;
            if (!$onehot0(resp)) begin
                n_fail++;
                $display("FAIL random_onehot_%0d: resp=%b expected at most one bit", i, resp);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        exp_q.delete();
        test_single();
        test_contention();
        test_preempt();
        test_idle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
